// File: rtl/i2c_slave_reg_ctrl_if.sv
// Signal bundle between the I2C byte engine / register RAM and the register-access controller.
// The slave modport is the controller's view; master is the engine/RAM side.
interface i2c_slave_reg_ctrl_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
);
    logic          start_det;
    logic          stop_det;
    logic          rw;
    logic          rx_valid;
    logic [DW-1:0] rx_byte;
    logic          ack_valid;
    logic          ack_out;
    logic          tx_valid;
    logic [DW-1:0] tx_byte;
    logic          tx_take;
    logic          mack_valid;
    logic          mack;
    logic          ram_w;
    logic [AW-1:0] ram_wadd;
    logic [DW-1:0] ram_din;
    logic          ram_re;
    logic [AW-1:0] ram_radd;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] ptr;
    logic          busy;

    modport slave (
        input  start_det, stop_det, rw, rx_valid, rx_byte, tx_take, mack_valid, mack, ram_dout,
        output ack_valid, ack_out, tx_valid, tx_byte, ram_w, ram_wadd, ram_din,
               ram_re, ram_radd, ptr, busy
    );

    modport master (
        output start_det, stop_det, rw, rx_valid, rx_byte, tx_take, mack_valid, mack, ram_dout,
        input  ack_valid, ack_out, tx_valid, tx_byte, ram_w, ram_wadd, ram_din,
               ram_re, ram_radd, ptr, busy
    );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-access controller for the I2C slave: pointer byte + auto-incrementing writes,
// RAM prefetch for master reads, and the ACK/NACK decision for each received byte.
module i2c_slave_reg_ctrl #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 8,
    parameter int unsigned ADDR_LIMIT = 32
) (
    input  logic                clk,
    input  logic                rst,
    i2c_slave_reg_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PTR, S_WDATA, S_RFETCH, S_RWAIT, S_RDATA
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_ack_valid, w_ack_valid_nxt;
    logic          r_ack_out,   w_ack_out_nxt;
    logic          r_tx_valid,  w_tx_valid_nxt;
    logic [DW-1:0] r_tx_byte,   w_tx_byte_nxt;
    logic          r_ram_w,     w_ram_w_nxt;
    logic [AW-1:0] r_ram_wadd,  w_ram_wadd_nxt;
    logic [DW-1:0] r_ram_din,   w_ram_din_nxt;
    logic          r_ram_re,    w_ram_re_nxt;
    logic [AW-1:0] r_ram_radd,  w_ram_radd_nxt;
    logic [AW-1:0] r_ptr,       w_ptr_nxt;
    logic          r_busy,      w_busy_nxt;

    logic [AW-1:0] w_ptr_inc;
    logic          w_rx_in_range;

    assign w_ptr_inc     = (r_ptr == AW'(ADDR_LIMIT - 1)) ? '0 : r_ptr + AW'(1);
    assign w_rx_in_range = (32'(bus.rx_byte) < ADDR_LIMIT);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ack_valid <= 1'b0;
            r_ack_out   <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= '0;
            r_ram_w     <= 1'b0;
            r_ram_wadd  <= '0;
            r_ram_din   <= '0;
            r_ram_re    <= 1'b0;
            r_ram_radd  <= '0;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack_valid <= w_ack_valid_nxt;
            r_ack_out   <= w_ack_out_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_ram_w     <= w_ram_w_nxt;
            r_ram_wadd  <= w_ram_wadd_nxt;
            r_ram_din   <= w_ram_din_nxt;
            r_ram_re    <= w_ram_re_nxt;
            r_ram_radd  <= w_ram_radd_nxt;
            r_ptr       <= w_ptr_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; START outranks STOP, STOP outranks byte events
    always_comb begin
        w_state_nxt     = r_state;
        w_ack_valid_nxt = 1'b0;
        w_ack_out_nxt   = r_ack_out;
        w_tx_valid_nxt  = r_tx_valid;
        w_tx_byte_nxt   = r_tx_byte;
        w_ram_w_nxt     = 1'b0;
        w_ram_wadd_nxt  = r_ram_wadd;
        w_ram_din_nxt   = r_ram_din;
        w_ram_re_nxt    = 1'b0;
        w_ram_radd_nxt  = r_ram_radd;
        w_ptr_nxt       = r_ptr;

        if (bus.start_det) begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = bus.rw ? S_RFETCH : S_PTR;
        end else if (bus.stop_det) begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
        end else begin
            case (r_state)
                S_PTR: begin
                    if (bus.rx_valid) begin
                        w_ack_valid_nxt = 1'b1;
                        w_ack_out_nxt   = w_rx_in_range;
                        if (w_rx_in_range) begin
                            w_ptr_nxt   = bus.rx_byte[AW-1:0];
                            w_state_nxt = S_WDATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid) begin
                        w_ram_w_nxt     = 1'b1;
                        w_ram_wadd_nxt  = r_ptr;
                        w_ram_din_nxt   = bus.rx_byte;
                        w_ack_valid_nxt = 1'b1;
                        w_ack_out_nxt   = 1'b1;
                        w_ptr_nxt       = w_ptr_inc;
                    end
                end
                S_RFETCH: w_state_nxt = S_RWAIT;
                S_RWAIT: begin
                    w_tx_byte_nxt  = bus.ram_dout;
                    w_tx_valid_nxt = 1'b1;
                    w_ptr_nxt      = w_ptr_inc;
                    w_state_nxt    = S_RDATA;
                end
                S_RDATA: begin
                    if (bus.tx_take) w_tx_valid_nxt = 1'b0;
                    if (bus.mack_valid) w_state_nxt = bus.mack ? S_RFETCH : S_IDLE;
                end
                default: ;
            endcase
        end

        // Every entry into RFETCH issues the read strobe for the current pointer
        if (w_state_nxt == S_RFETCH) begin
            w_ram_re_nxt   = 1'b1;
            w_ram_radd_nxt = r_ptr;
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.ack_valid = r_ack_valid;
    assign bus.ack_out   = r_ack_out;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_byte   = r_tx_byte;
    assign bus.ram_w     = r_ram_w;
    assign bus.ram_wadd  = r_ram_wadd;
    assign bus.ram_din   = r_ram_din;
    assign bus.ram_re    = r_ram_re;
    assign bus.ram_radd  = r_ram_radd;
    assign bus.ptr       = r_ptr;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Bench for i2c_slave_reg_ctrl: table of write transactions, directed corner sequences,
// and random write/read traffic scored against a transaction-level register-map model.
module tb_i2c_slave_reg_ctrl;
    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 8;
    localparam int unsigned LIM = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_slave_reg_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    i2c_slave_reg_ctrl #(.AW(AW), .DW(DW), .ADDR_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Register RAM with a backdoor write port for preloading
    logic [DW-1:0] mem [LIM];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_w) mem[bus.ram_wadd] <= bus.ram_din;
        if (bus.ram_re) bus.ram_dout <= mem[bus.ram_radd];
    end

    // Observed DUT events
    typedef struct { logic [7:0] b; int lat; } tx_ev_t;
    logic        q_ack [$];
    logic [12:0] q_w   [$];
    logic [4:0]  q_re  [$];
    tx_ev_t      q_tx  [$];
    int   cyc;
    int   last_re_cyc;
    logic prev_txv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack_valid) q_ack.push_back(bus.ack_out);
            if (bus.ram_w) q_w.push_back({bus.ram_wadd, bus.ram_din});
            if (bus.ram_re) begin
                q_re.push_back(bus.ram_radd);
                last_re_cyc = cyc;
            end
            if (bus.tx_valid && !prev_txv) q_tx.push_back('{b: bus.tx_byte, lat: cyc - last_re_cyc});
        end
        prev_txv = bus.tx_valid;
    end

    // Reference model: register map, pointer and expected event streams
    logic [7:0]  m_mem [LIM];
    logic [4:0]  m_ptr;
    logic        e_ack [$];
    logic [12:0] e_w   [$];
    logic [4:0]  e_re  [$];
    logic [7:0]  e_tx  [$];
    logic [7:0]  wbuf  [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not observed", name);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4:0] inc(input logic [4:0] p);
        return 5'((int'(p) + 1) % LIM);
    endfunction

    task automatic send_start(input logic r);
        bus.start_det = 1'b1; bus.rw = r;
        tick();
        bus.start_det = 1'b0; bus.rw = 1'b0;
        tick(2);
    endtask

    task automatic send_stop();
        bus.stop_det = 1'b1;
        tick();
        bus.stop_det = 1'b0;
        tick(2);
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_valid = 1'b1; bus.rx_byte = b;
        tick();
        bus.rx_valid = 1'b0;
        tick(3);
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic do_write(input logic [7:0] p, input int n, input bit with_stop);
        logic ok;
        send_start(1'b0);
        send_rx(p);
        ok = (int'(p) < LIM);
        e_ack.push_back(ok);
        if (ok) m_ptr = p[4:0];
        for (int i = 0; i < n; i++) begin
            send_rx(wbuf[i]);
            if (ok) begin
                e_ack.push_back(1'b1);
                e_w.push_back({m_ptr, wbuf[i]});
                m_mem[m_ptr] = wbuf[i];
                m_ptr = inc(m_ptr);
            end
        end
        if (with_stop) send_stop();
    endtask

    task automatic do_read(input int n);
        int k;
        send_start(1'b1);
        for (int i = 0; i < n; i++) begin
            e_re.push_back(m_ptr);
            e_tx.push_back(m_mem[m_ptr]);
            m_ptr = inc(m_ptr);
            k = 0;
            while (!bus.tx_valid && k < 20) begin
                tick();
                k++;
            end
            chk($sformatf("tx_valid_wait[%0d]", i), 32'(bus.tx_valid), 32'd1);
            bus.tx_take = 1'b1;
            tick();
            bus.tx_take = 1'b0;
            chk($sformatf("tx_take_clr[%0d]", i), 32'(bus.tx_valid), 32'd0);
            tick(2);
            bus.mack_valid = 1'b1; bus.mack = (i < n - 1);
            tick();
            bus.mack_valid = 1'b0; bus.mack = 1'b0;
            tick(2);
        end
    endtask

    task automatic flush();
        q_ack.delete(); q_w.delete(); q_re.delete(); q_tx.delete();
        e_ack.delete(); e_w.delete(); e_re.delete(); e_tx.delete();
    endtask

    task automatic drain(input string tag);
        tx_ev_t t;
        tick(2);
        while (e_ack.size() > 0) begin
            if (q_ack.size() == 0) begin missing({tag, " ack"}); void'(e_ack.pop_front()); end
            else chk({tag, " ack"}, 32'(q_ack.pop_front()), 32'(e_ack.pop_front()));
        end
        while (e_w.size() > 0) begin
            if (q_w.size() == 0) begin missing({tag, " ram_w"}); void'(e_w.pop_front()); end
            else chk({tag, " ram_w addr/data"}, 32'(q_w.pop_front()), 32'(e_w.pop_front()));
        end
        while (e_re.size() > 0) begin
            if (q_re.size() == 0) begin missing({tag, " ram_re"}); void'(e_re.pop_front()); end
            else chk({tag, " ram_radd"}, 32'(q_re.pop_front()), 32'(e_re.pop_front()));
        end
        while (e_tx.size() > 0) begin
            if (q_tx.size() == 0) begin missing({tag, " tx"}); void'(e_tx.pop_front()); end
            else begin
                t = q_tx.pop_front();
                chk({tag, " tx_byte"}, 32'(t.b), 32'(e_tx.pop_front()));
                chk({tag, " re_to_tx_latency"}, 32'(t.lat), 32'd2);
            end
        end
        chk({tag, " extra_events"}, 32'(q_ack.size() + q_w.size() + q_re.size() + q_tx.size()), 32'd0);
        flush();
    endtask

    typedef struct {
        logic [7:0] p;
        int         n;
        logic [7:0] d0, d1, d2;
        logic       exp_ack;
        int         exp_nw;
        logic [4:0] exp_ptr;
    } wvec_t;

    wvec_t tbl [6];

    initial begin
        tbl[0] = '{8'h05, 2, 8'hA1, 8'hB2, 8'h00, 1'b1, 2, 5'd7};
        tbl[1] = '{8'h1F, 2, 8'h11, 8'h22, 8'h00, 1'b1, 2, 5'd1};
        tbl[2] = '{8'h20, 1, 8'h55, 8'h00, 8'h00, 1'b0, 0, 5'd1};
        tbl[3] = '{8'h00, 3, 8'h01, 8'h02, 8'h03, 1'b1, 3, 5'd3};
        tbl[4] = '{8'hFF, 0, 8'h00, 8'h00, 8'h00, 1'b0, 0, 5'd3};
        tbl[5] = '{8'h1E, 3, 8'h9A, 8'h9B, 8'h9C, 1'b1, 3, 5'd1};

        bus.start_det = 0; bus.stop_det = 0; bus.rw = 0; bus.rx_valid = 0; bus.rx_byte = '0;
        bus.tx_take = 0; bus.mack_valid = 0; bus.mack = 0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        rst = 1'b1;
        tick(2);
        for (int a = 0; a < int'(LIM); a++) preload(5'(a), 8'($urandom));
        m_ptr = '0;
        rst = 1'b0;
        tick(5);

        chk("rst ack_valid", 32'(bus.ack_valid), 0);
        chk("rst ack_out",   32'(bus.ack_out),   0);
        chk("rst tx_valid",  32'(bus.tx_valid),  0);
        chk("rst tx_byte",   32'(bus.tx_byte),   0);
        chk("rst ram_w",     32'(bus.ram_w),     0);
        chk("rst ram_wadd",  32'(bus.ram_wadd),  0);
        chk("rst ram_din",   32'(bus.ram_din),   0);
        chk("rst ram_re",    32'(bus.ram_re),    0);
        chk("rst ram_radd",  32'(bus.ram_radd),  0);
        chk("rst ptr",       32'(bus.ptr),       0);
        chk("rst busy",      32'(bus.busy),      0);
        flush();

        for (int i = 0; i < 6; i++) begin
            wbuf[0] = tbl[i].d0; wbuf[1] = tbl[i].d1; wbuf[2] = tbl[i].d2;
            do_write(tbl[i].p, tbl[i].n, 1'b0);
            tick(2);
            chk($sformatf("tbl[%0d] first_ack", i), q_ack.size() > 0 ? 32'(q_ack[0]) : 32'hDEAD, 32'(tbl[i].exp_ack));
            chk($sformatf("tbl[%0d] n_writes", i), 32'(q_w.size()), 32'(tbl[i].exp_nw));
            chk($sformatf("tbl[%0d] busy_before_stop", i), 32'(bus.busy), 32'(tbl[i].exp_ack));
            send_stop();
            drain($sformatf("tbl[%0d]", i));
            chk($sformatf("tbl[%0d] ptr", i), 32'(bus.ptr), 32'(tbl[i].exp_ptr));
            chk($sformatf("tbl[%0d] busy", i), 32'(bus.busy), 0);
        end

        // Combined format: pointer write then repeated START read
        preload(5'd3, 8'hFE);
        preload(5'd4, 8'h3C);
        do_write(8'h03, 0, 1'b0);
        do_read(2);
        drain("wr_then_rd");
        chk("wr_then_rd ptr", 32'(bus.ptr), 32'd5);
        chk("wr_then_rd busy", 32'(bus.busy), 0);

        // START beats STOP and rx_valid arriving in the same cycle during WDATA
        wbuf[0] = 8'h44;
        do_write(8'h0A, 1, 1'b0);
        bus.start_det = 1; bus.rw = 0; bus.stop_det = 1; bus.rx_valid = 1; bus.rx_byte = 8'h77;
        tick();
        bus.start_det = 0; bus.stop_det = 0; bus.rx_valid = 0;
        tick(2);
        chk("prio busy", 32'(bus.busy), 1);
        chk("prio ptr", 32'(bus.ptr), 32'h0B);
        send_rx(8'h02);
        e_ack.push_back(1'b1);
        m_ptr = 5'd2;
        chk("prio ptr_reloaded", 32'(bus.ptr), 32'd2);
        send_stop();
        drain("prio");

        // Reset in the middle of a read aborts everything
        bus.start_det = 1; bus.rw = 1;
        tick();
        bus.start_det = 0; bus.rw = 0;
        chk("midrd ram_re", 32'(bus.ram_re), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrd ptr", 32'(bus.ptr), 0);
        chk("midrd busy", 32'(bus.busy), 0);
        chk("midrd ram_re_cleared", 32'(bus.ram_re), 0);
        tick(3);
        chk("midrd no_tx", 32'(bus.tx_valid), 0);
        m_ptr = '0;
        flush();

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int sel, n;
            logic [7:0] p;
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                p = 8'($urandom_range(0, 39));
                n = int'($urandom_range(0, 4));
                for (int j = 0; j < n; j++) wbuf[j] = 8'($urandom);
                do_write(p, n, 1'b1);
            end else if (sel == 1) begin
                do_read(int'($urandom_range(1, 4)));
            end else begin
                p = 8'($urandom_range(0, 31));
                do_write(p, 0, 1'b0);
                do_read(int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 3) == 0) begin
                send_rx(8'($urandom));
                bus.tx_take = 1; bus.mack_valid = 1; bus.mack = 1;
                tick();
                bus.tx_take = 0; bus.mack_valid = 0; bus.mack = 0;
                tick(2);
            end
            drain($sformatf("rnd[%0d]", it));
            chk($sformatf("rnd[%0d] ptr", it), 32'(bus.ptr), 32'(m_ptr));
            chk($sformatf("rnd[%0d] busy", it), 32'(bus.busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_reg_ctrl.md
Name: i2c_slave_reg_ctrl

Overview:
- Register-access controller for the I2C slave. Sits between the byte-level I2C engine and the 32x8 register RAM.
- Converts received bytes into a register pointer plus auto-incrementing writes.
- For master reads, prefetches RAM bytes and presents them to the engine for transmission.
- Issues the ACK/NACK decision for every received byte.

Parameters:
- AW, 5, register address width.
- DW, 8, data width.
- ADDR_LIMIT, 32, number of valid registers; pointer bytes at or above this value are NACKed; the pointer wraps at this value.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- start_det  input  1  one-cycle pulse: START or repeated START plus matching slave address accepted
- stop_det  input  1  one-cycle pulse: STOP seen
- rw  input  1  direction from address byte (0 write, 1 read); valid with start_det
- rx_valid  input  1  one-cycle pulse: rx_byte holds a received data byte
- rx_byte  input  DW  received byte
- ack_valid  output  1  one-cycle pulse: ack_out is valid
- ack_out  output  1  1 = ACK, 0 = NACK for the last rx byte
- tx_valid  output  1  tx_byte ready for transmission
- tx_byte  output  DW  byte to transmit
- tx_take  input  1  pulse: engine loaded tx_byte into its shifter
- mack_valid  input  1  pulse: master ACK bit sampled after a tx byte
- mack  input  1  1 = master ACK (continue), 0 = NACK (end read)
- ram_w  output  1  RAM write strobe
- ram_wadd  output  AW  RAM write address
- ram_din  output  DW  RAM write data
- ram_re  output  1  RAM read strobe
- ram_radd  output  AW  RAM read address
- ram_dout  input  DW  RAM read data, valid one clock after ram_re
- ptr  output  AW  current register pointer (debug/status)
- busy  output  1  state != IDLE

Behaviour:
- Reset:
  - State IDLE; ptr = 0.
  - All outputs 0: ram_w, ram_re, ram_wadd, ram_radd, ram_din, tx_valid, tx_byte, ack_valid, ack_out, busy.
  - Reset mid-transaction aborts without completing pending strobes.
- All outputs are registered.
- ram_w, ram_re and ack_valid are single-cycle pulses.
- States: IDLE, PTR, WDATA, RFETCH, RWAIT, RDATA.
- Any state, start_det=1:
  - rw=0 -> PTR.
  - rw=1 -> RFETCH.
  - Clears tx_valid.
  - start_det wins over stop_det or rx_valid in the same cycle.
- Any state, stop_det=1 (no start_det) -> IDLE. Clears tx_valid; ptr is retained.
- PTR, on rx_valid:
  - If rx_byte < ADDR_LIMIT: ptr <= rx_byte[AW-1:0], ack_out=1, go to WDATA.
  - Else: ack_out=0, ptr unchanged, go to IDLE.
  - ack_valid pulses in the cycle after rx_valid.
- WDATA, on rx_valid: in the next cycle, ram_w=1, ram_wadd=ptr, ram_din=rx_byte, ack_valid=1, ack_out=1.
- Pointer increment (writes and reads): ptr <= (ptr == ADDR_LIMIT-1) ? 0 : ptr+1.
- RFETCH (one cycle): ram_re=1, ram_radd=ptr -> RWAIT.
- RWAIT (one cycle): tx_byte <= ram_dout, tx_valid <= 1, ptr increments -> RDATA.
- Read latency: start_det sampled at edge N -> ram_re high after N -> tx_valid high after edge N+2.
- RDATA:
  - tx_take clears tx_valid next cycle.
  - mack_valid with mack=1 -> RFETCH (next byte).
  - mack_valid with mack=0 -> IDLE.
- Ignored inputs:
  - rx_valid is ignored in IDLE, RFETCH, RWAIT and RDATA; no ack_valid is produced.
  - tx_take and mack_valid are ignored outside RDATA.
- Repeated START after the pointer write (write-then-read combined format) reads from the new ptr.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, ptr=0, busy=0.
- start_det rw=0; rx 0x05; rx 0xA1; rx 0xB2; stop_det -> ack_out=1 three times; ram_w at addr 5 with 0xA1, then addr 6 with 0xB2; ptr=7; IDLE.
- start_det rw=0; rx 0x1F; rx 0x11; rx 0x22 -> writes at addr 31 then addr 0 (wrap); ptr=1.
- start_det rw=0; rx 0x20 -> ack_out=0; no ram_w; ptr unchanged; state IDLE.
- RAM preloaded 0xFE. start_det rw=0; rx 0x03; repeated start_det rw=1:
  - ram_re with radd=3; tx_valid with 0xFE exactly 2 cycles after ram_re asserts.
  - tx_take, mack=1 -> next fetch at addr 4.
  - mack=0 -> IDLE, ptr=5.
- During WDATA, drive start_det and stop_det in the same cycle as rx_valid -> no ram_w; state PTR (start priority).
- Reset asserted mid-read -> state returns to IDLE, ptr=0.
